// File: rtl/softstart_pkg.sv
// Shared encodings and default widths for the soft-start sequencer slice.
package softstart_pkg;

   localparam int SIGNAL_W_DEF = 12;
   localparam int PRESC_W_DEF  = 16;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RAMP_UP   = 3'd1;
   localparam logic [2:0] ST_REGULATE  = 3'd2;
   localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
   localparam logic [2:0] ST_FAULT     = 3'd4;

   // Power stage is energised in every state that moves or holds the reference.
   function automatic logic is_active(input logic [2:0] st);
      return (st == ST_RAMP_UP) || (st == ST_REGULATE) || (st == ST_RAMP_DOWN);
   endfunction

endpackage

// File: rtl/softstart_sequencer_tick_divider.sv
// Prescaler counter: one tick every period_i+1 cycles while running.
module tick_divider #(
   parameter int W = 16
) (
   input  logic         aclk,
   input  logic         resetn,
   input  logic         run_i,
   input  logic         clear_i,
   input  logic [W-1:0] period_i,
   output logic         tick_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick_o = run_i && (cnt_q == period_i);

   // A clear restarts the phase so the first tick lands period_i+1 cycles later.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!run_i || clear_i || tick_o) cnt_d = '0;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/softstart_sequencer.sv
// Soft-start/soft-stop reference sequencer: FSM plus one-LSB-per-tick setpoint slew.
module softstart_sequencer
   import softstart_pkg::*;
#(
   parameter int SIGNAL_WIDTH    = SIGNAL_W_DEF,
   parameter int PRESCALER_WIDTH = PRESC_W_DEF
) (
   input  logic                       aclk,
   input  logic                       resetn,
   input  logic                       start_i,
   input  logic                       stop_i,
   input  logic                       fault_i,
   input  logic                       fault_clear_i,
   input  logic [SIGNAL_WIDTH-1:0]    target_i,
   input  logic [PRESCALER_WIDTH-1:0] prescaler_i,
   output logic [SIGNAL_WIDTH-1:0]    setpoint_o,
   output logic                       step_tick_o,
   output logic                       pwm_enable_o,
   output logic                       done_o,
   output logic [2:0]                 state_o,
   output logic                       busy_o
);

   logic [2:0]                 state_q, state_d;
   logic [SIGNAL_WIDTH-1:0]    sp_q, sp_d, dest;
   logic [PRESCALER_WIDTH-1:0] presc_q, presc_d;
   logic                       pwm_q, pwm_d;
   logic                       start_acc;
   logic                       tick;
   logic                       run, clear;

   assign run   = is_active(state_q);
   assign clear = (state_d != state_q) || start_acc;

   tick_divider #(.W(PRESCALER_WIDTH)) u_tick (
      .aclk     (aclk),
      .resetn   (resetn),
      .run_i    (run),
      .clear_i  (clear),
      .period_i (presc_q),
      .tick_o   (tick)
   );

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         sp_q    <= '0;
         presc_q <= '0;
         pwm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         presc_q <= presc_d;
         pwm_q   <= pwm_d;
      end
   end

   // Priority is fault > stop > start; a start in RAMP_UP defers the REGULATE hand-off.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      if (fault_i) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i && !stop_i) begin
                  state_d   = ST_RAMP_UP;
                  start_acc = 1'b1;
               end
            end
            ST_RAMP_UP: begin
               if (stop_i)               state_d   = ST_RAMP_DOWN;
               else if (start_i)         start_acc = 1'b1;
               else if (sp_q == target_i) state_d  = ST_REGULATE;
            end
            ST_REGULATE: begin
               if (stop_i) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
               if (start_i && !stop_i) begin
                  state_d   = ST_RAMP_UP;
                  start_acc = 1'b1;
               end else if (sp_q == '0) begin
                  state_d = ST_IDLE;
               end
            end
            ST_FAULT: begin
               if (fault_clear_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Ramp-down ignores the live target; slewing stops on equality so no wrap occurs.
   always_comb begin
      dest    = (state_q == ST_RAMP_DOWN) ? '0 : target_i;
      sp_d    = sp_q;
      presc_d = start_acc ? prescaler_i : presc_q;
      pwm_d   = is_active(state_d);
      if (state_d == ST_FAULT) begin
         sp_d = '0;
      end else if (tick) begin
         if (sp_q < dest)      sp_d = sp_q + 1'b1;
         else if (sp_q > dest) sp_d = sp_q - 1'b1;
      end
   end

   always_comb begin
      state_o      = state_q;
      setpoint_o   = sp_q;
      pwm_enable_o = pwm_q;
      step_tick_o  = tick;
      done_o       = (state_q == ST_RAMP_UP) && (state_d == ST_REGULATE);
      busy_o       = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
   end

endmodule

// File: tb/tb_softstart_sequencer.sv
// Directed scenarios plus randomized run against a countdown-based reference model.
module tb_softstart_sequencer;

   logic        aclk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0, stop = 1'b0, fault = 1'b0, fault_clear = 1'b0;
   logic [11:0] target = '0;
   logic [15:0] prescaler = '0;
   logic [11:0] setpoint;
   logic        step_tick, pwm_enable, done, busy;
   logic [2:0]  state;

   int errors = 0;
   int checks = 0;

   softstart_sequencer dut (
      .aclk(aclk), .resetn(resetn), .start_i(start), .stop_i(stop), .fault_i(fault),
      .fault_clear_i(fault_clear), .target_i(target), .prescaler_i(prescaler),
      .setpoint_o(setpoint), .step_tick_o(step_tick), .pwm_enable_o(pwm_enable),
      .done_o(done), .state_o(state), .busy_o(busy)
   );

   always #5 aclk = ~aclk;

   // Reference model: m_wait counts down the cycles left until the next slew opportunity.
   int m_state = 0, m_sp = 0, m_wait = 0, m_presc = 0;
   bit m_pwm = 0;

   function automatic bit m_tick();
      return (m_state >= 1 && m_state <= 3) && (m_wait == 0);
   endfunction
   function automatic bit m_done();
      return (m_state == 1) && !fault && !stop && !start && (m_sp == int'(target));
   endfunction

   always @(posedge aclk) begin : ref_model
      int ns, sp, p, w, dst;
      bit acc, tk;
      tk = m_tick(); ns = m_state; sp = m_sp; p = m_presc; w = m_wait; acc = 0;
      if (!resetn) begin
         ns = 0; sp = 0; p = 0; w = 0;
      end else begin
         dst = (m_state == 3) ? 0 : int'(target);
         if (tk && sp < dst) sp = sp + 1;
         else if (tk && sp > dst) sp = sp - 1;
         if (fault) ns = 4;
         else case (m_state)
            0: if (start && !stop) begin ns = 1; acc = 1; end
            1: if (stop) ns = 3; else if (start) acc = 1; else if (m_sp == int'(target)) ns = 2;
            2: if (stop) ns = 3;
            3: if (start && !stop) begin ns = 1; acc = 1; end else if (m_sp == 0) ns = 0;
            4: if (fault_clear) ns = 0;
            default: ns = 0;
         endcase
         if (acc) p = int'(prescaler);
         if (ns == 4) sp = 0;
         if (ns != m_state || acc || tk) w = p;
         else w = m_wait - 1;
      end
      m_state <= ns; m_sp <= sp; m_presc <= p; m_wait <= w;
      m_pwm   <= (ns >= 1 && ns <= 3);
   end

   task automatic cyc();
      @(posedge aclk); #1;
      start = 0; stop = 0; fault_clear = 0;
   endtask

   task automatic do_reset();
      resetn = 0; start = 0; stop = 0; fault = 0; fault_clear = 0;
      cyc(); cyc();
      resetn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge aclk);
      checks++;
      if ({state, setpoint, pwm_enable, step_tick, done, busy} !== 19'd0) begin
         errors++;
         $display("FAIL reset: state=%0d sp=%0d pwm=%b tick=%b done=%b busy=%b, required all 0",
                  state, setpoint, pwm_enable, step_tick, done, busy);
      end
      stop = 1; target = 12'd33; cyc(); cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd0 || pwm_enable !== 1'b0) begin
         errors++;
         $display("FAIL idle_stop_ignored: state=%0d pwm=%b, required 0/0", state, pwm_enable);
      end
   endtask

   task automatic test_ramp_up();
      logic [16:0] got, exp;
      do_reset();
      prescaler = 16'd3; target = 12'd10; start = 1;
      cyc();
      for (int c = 0; c <= 40; c++) begin
         @(negedge aclk);
         got = {setpoint, state, pwm_enable, step_tick, done};
         exp = {12'(c / 4), 3'd1, 1'b1, 1'(c % 4 == 3), 1'(c == 40)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL ramp_up c=%0d: sp=%0d st=%0d pwm=%b tick=%b done=%b, required sp=%0d st=1 pwm=1 tick=%b done=%b",
                     c, setpoint, state, pwm_enable, step_tick, done, c / 4, c % 4 == 3, c == 40);
         end
         cyc();
      end
      @(negedge aclk);
      checks++;
      if (state !== 3'd2 || done !== 1'b0 || setpoint !== 12'd10 || pwm_enable !== 1'b1) begin
         errors++;
         $display("FAIL ramp_up_regulate: st=%0d done=%b sp=%0d pwm=%b, required st=2 done=0 sp=10 pwm=1",
                  state, done, setpoint, pwm_enable);
      end
   endtask

   task automatic test_track();
      bit ok = 0;
      int exp_sp[5] = '{10, 9, 8, 7, 7};
      do_reset();
      prescaler = 16'd0; target = 12'd10; start = 1;
      cyc();
      for (int i = 0; i < 60; i++) begin
         @(negedge aclk);
         if (state == 3'd2) begin ok = 1; break; end
         cyc();
      end
      checks++;
      if (!ok || setpoint !== 12'd10) begin
         errors++;
         $display("FAIL track_reach: reached=%0d sp=%0d, required reached=1 sp=10", ok, setpoint);
      end
      target = 12'd7;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge aclk);
         checks++;
         if (setpoint !== 12'(exp_sp[k]) || state !== 3'd2 || done !== 1'b0) begin
            errors++;
            $display("FAIL track k=%0d: sp=%0d st=%0d done=%b, required sp=%0d st=2 done=0",
                     k, setpoint, state, done, exp_sp[k]);
         end
         cyc();
      end
   endtask

   task automatic test_ramp_down();
      bit ok = 0;
      do_reset();
      prescaler = 16'd1; target = 12'd5; start = 1;
      cyc();
      for (int i = 0; i < 60; i++) begin
         @(negedge aclk);
         if (state == 3'd2) begin ok = 1; break; end
         cyc();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ramp_down_reach: no REGULATE within bound, required REGULATE");
      end
      stop = 1;
      cyc();
      for (int c = 0; c <= 10; c++) begin
         @(negedge aclk);
         checks++;
         if (state !== 3'd3 || setpoint !== 12'(5 - c / 2) || pwm_enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ramp_down c=%0d: st=%0d sp=%0d pwm=%b busy=%b, required st=3 sp=%0d pwm=1 busy=1",
                     c, state, setpoint, pwm_enable, busy, 5 - c / 2);
         end
         cyc();
      end
      @(negedge aclk);
      checks++;
      if (state !== 3'd0 || pwm_enable !== 1'b0 || busy !== 1'b0 || setpoint !== 12'd0) begin
         errors++;
         $display("FAIL ramp_down_idle: st=%0d pwm=%b busy=%b sp=%0d, required 0/0/0/0",
                  state, pwm_enable, busy, setpoint);
      end
   endtask

   task automatic test_resume();
      bit ok;
      int ndone = 0, minsp = 4;
      do_reset();
      prescaler = 16'd1; target = 12'd10; start = 1;
      cyc();
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk);
         if (state == 3'd1 && setpoint == 12'd6 && !step_tick) begin ok = 1; break; end
         cyc();
      end
      stop = 1; cyc();
      for (int i = 0; i < 100 && ok; i++) begin
         @(negedge aclk);
         if (state == 3'd3 && setpoint == 12'd4 && !step_tick) break;
         if (i == 99) ok = 0;
         cyc();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL resume_setup: did not reach sp=6 up then sp=4 down within bound");
      end
      start = 1; cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd1 || setpoint !== 12'd4) begin
         errors++;
         $display("FAIL resume_entry: st=%0d sp=%0d, required st=1 sp=4", state, setpoint);
      end
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk);
         if (done) ndone++;
         if (int'(setpoint) < minsp) minsp = int'(setpoint);
         if (state == 3'd2) begin ok = 1; break; end
         cyc();
      end
      checks++;
      if (!ok || ndone != 1 || minsp != 4 || setpoint !== 12'd10) begin
         errors++;
         $display("FAIL resume: reached=%0d done_pulses=%0d min_sp=%0d sp=%0d, required 1/1/4/10",
                  ok, ndone, minsp, setpoint);
      end
   endtask

   task automatic test_fault();
      bit ok = 0;
      do_reset();
      prescaler = 16'd0; target = 12'd12; start = 1;
      cyc();
      for (int i = 0; i < 60; i++) begin
         @(negedge aclk);
         if (state == 3'd1 && setpoint == 12'd8) begin ok = 1; break; end
         cyc();
      end
      fault = 1; cyc();
      @(negedge aclk);
      checks++;
      if (!ok || state !== 3'd4 || setpoint !== 12'd0 || pwm_enable !== 1'b0 || step_tick !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fault_entry: reached=%0d st=%0d sp=%0d pwm=%b tick=%b busy=%b, required 1/4/0/0/0/0",
                  ok, state, setpoint, pwm_enable, step_tick, busy);
      end
      start = 1; cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd4 || pwm_enable !== 1'b0) begin
         errors++;
         $display("FAIL fault_start_ignored: st=%0d pwm=%b, required 4/0", state, pwm_enable);
      end
      fault_clear = 1; cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd4) begin
         errors++;
         $display("FAIL fault_clear_while_high: st=%0d, required 4", state);
      end
      fault = 0; cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd4) begin
         errors++;
         $display("FAIL fault_held: st=%0d, required 4", state);
      end
      fault_clear = 1; cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd0 || setpoint !== 12'd0 || pwm_enable !== 1'b0) begin
         errors++;
         $display("FAIL fault_clear: st=%0d sp=%0d pwm=%b, required 0/0/0", state, setpoint, pwm_enable);
      end
   endtask

   task automatic test_start_stop();
      do_reset();
      start = 1; stop = 1; cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd0 || pwm_enable !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_stop_same: st=%0d pwm=%b busy=%b, required 0/0/0", state, pwm_enable, busy);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      prescaler = 16'd0; target = 12'd20; start = 1;
      cyc(); cyc(); cyc(); cyc();
      @(negedge aclk);
      checks++;
      if (state !== 3'd1 || setpoint !== 12'd3 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_ramp_pre: st=%0d sp=%0d busy=%b, required 1/3/1", state, setpoint, busy);
      end
      resetn = 0; cyc();
      @(negedge aclk);
      checks++;
      if ({state, setpoint, pwm_enable, step_tick, done, busy} !== 19'd0) begin
         errors++;
         $display("FAIL mid_ramp_reset: st=%0d sp=%0d pwm=%b tick=%b done=%b busy=%b, required all 0",
                  state, setpoint, pwm_enable, step_tick, done, busy);
      end
      resetn = 1; cyc();
   endtask

   task automatic test_random();
      logic [18:0] got, exp;
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         resetn      = ($urandom_range(0, 999) >= 3);
         start       = ($urandom_range(0, 99) < 4);
         stop        = ($urandom_range(0, 99) < 2);
         fault_clear = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 99) < 2) fault = ~fault;
         if ($urandom_range(0, 99) < 3) target = 12'($urandom_range(0, 40));
         prescaler = 16'($urandom_range(0, 3));
         @(negedge aclk);
         got = {state, setpoint, pwm_enable, step_tick, done, busy};
         exp = {3'(m_state), 12'(m_sp), m_pwm, m_tick(), m_done(), 1'(m_state == 1 || m_state == 3)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random n=%0d: st=%0d sp=%0d pwm=%b tick=%b done=%b busy=%b, required st=%0d sp=%0d pwm=%b tick=%b done=%b busy=%b",
                     n, state, setpoint, pwm_enable, step_tick, done, busy,
                     m_state, m_sp, m_pwm, m_tick(), m_done(), m_state == 1 || m_state == 3);
         end
         @(posedge aclk); #1;
      end
      fault = 0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_track();
      test_ramp_down();
      test_resume();
      test_fault();
      test_start_stop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/softstart_sequencer.md
Name: softstart_sequencer

Overview:
Controller that sequences the converter reference setpoint through soft-start, regulation and soft-stop.
- Generates the step-enable tick from a programmable prescaler.
- Slews an internal setpoint one LSB per tick toward the commanded target.
- Gates the power stage through pwm_enable.
- Handles fault shutdown.
- Sits between the register/command interface and the voltage-loop reference input.

Parameters:
signal_width, 12, width of target and setpoint
prescaler_width, 16, width of prescaler value

Ports:
aclk  in  1  clock
resetn  in  1  reset, synchronous, active-low
start  in  1  one-cycle command pulse: begin/resume ramp up
stop  in  1  one-cycle command pulse: begin ramp down
fault  in  1  level, external fault (overcurrent/overvoltage)
fault_clear  in  1  one-cycle pulse, leave FAULT
target  in  signal_width  commanded setpoint, unsigned, live
prescaler  in  prescaler_width  tick every prescaler+1 cycles
setpoint  out  signal_width  ramped reference, registered
step_tick  out  1  one-cycle pulse on every slew opportunity
pwm_enable  out  1  power stage enable, registered
done  out  1  one-cycle pulse when ramp-up reaches target
state  out  3  current state encoding
busy  out  1  high in RAMP_UP or RAMP_DOWN

Behaviour:
- Reset: state=IDLE, setpoint=0, pwm_enable=0, step_tick=0, done=0, busy=0, prescaler counter=0, latched prescaler=0.
- State encoding: IDLE=0, RAMP_UP=1, REGULATE=2, RAMP_DOWN=3, FAULT=4.
- Command priority within one cycle: fault > stop > start. start and stop in the same cycle resolve as stop.

Tick generator:
- prescaler is latched on every accepted start.
- Counter runs in RAMP_UP, REGULATE and RAMP_DOWN; it is held at 0 in IDLE and FAULT.
- Counter clears on every state change.
- step_tick is asserted when counter == latched prescaler; the counter then wraps to 0.
- Latched prescaler 0 gives a tick every cycle.
- First tick after entering a ramp state occurs prescaler+1 cycles after entry.

Setpoint update (registered, visible the cycle after step_tick):
- setpoint < target: +1.
- setpoint > target: -1.
- Equal: hold. No wrap-around is possible.

State transitions:
- IDLE:
  - start -> RAMP_UP; pwm_enable=1 from the next cycle.
  - stop is ignored.
- RAMP_UP:
  - On any cycle with setpoint == target -> REGULATE, with done pulsed in the same cycle as the transition.
  - start with target == current setpoint -> RAMP_UP, then REGULATE on the following cycle.
  - stop -> RAMP_DOWN.
- REGULATE:
  - setpoint tracks target changes at one LSB per tick.
  - stop -> RAMP_DOWN.
  - start is ignored; done is not re-pulsed.
- RAMP_DOWN:
  - Slews toward 0 on ticks, ignoring target.
  - setpoint == 0 -> IDLE; pwm_enable drops to 0 in the same registered update.
  - start -> RAMP_UP, resuming from the current setpoint with no reset to 0.
- FAULT (entered from any state while fault is high):
  - Next cycle: setpoint=0, pwm_enable=0, counter=0.
  - start and stop are ignored.
  - fault_clear while fault is low -> IDLE.
  - fault_clear while fault is high is ignored.
- Reset mid-ramp returns to the reset values within one cycle. No partial state is retained.

Decomposition:
- Package softstart_pkg holds:
  - state encoding localparams ST_IDLE..ST_FAULT;
  - default width constants.
- Sub-module tick_divider (prescaler counter):
  - inputs: aclk, resetn, run, clear, period;
  - output: tick.
- FSM and setpoint register remain in softstart_sequencer.

Test Plan:
1. prescaler=3, target=10, start pulse.
   - setpoint increments every 4 cycles and reaches 10 after 40 cycles from entry.
   - done is pulsed for 1 cycle as state goes 1->2.
   - pwm_enable=1 throughout.
2. In REGULATE at 10, target changed to 7 with prescaler=0.
   - setpoint steps 9, 8, 7 on consecutive cycles, then holds.
   - state stays 2; no done pulse.
3. Stop in REGULATE at setpoint=5, prescaler=1.
   - RAMP_DOWN decrements every 2 cycles down to 0.
   - state=IDLE and pwm_enable=0 follow.
4. Stop at setpoint=6 during ramp-up, then start pulse at setpoint=4.
   - Ramp resumes upward from 4 to target 10.
   - done is pulsed once on arrival.
5. fault asserted at setpoint=8 mid-ramp.
   - Next cycle: state=4, setpoint=0, pwm_enable=0.
   - start ignored; fault_clear while fault=1 ignored.
   - fault_clear after fault=0 -> IDLE.
6. start and stop in the same cycle from IDLE: remains IDLE. resetn=0 mid-RAMP_UP: all outputs 0 next cycle.
